// File: rtl/mac_result_serializer.sv
// Buffers completed accumulator results in a small FIFO and streams each one out a byte per valid/ready transfer.
// Optional MAC_SER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module mac_result_serializer #(
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [ACC_WIDTH-1:0] result_i,
    input  logic                 result_valid_i,
    output logic [7:0]           byte_o,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 overrun_o,
    input  logic                 clear_i
);

    localparam int NBYTES = ACC_WIDTH / 8;
`ifdef MAC_SER_CHECKSUM_EN
    localparam int FRAME_LEN = NBYTES + 1;
`else
    localparam int FRAME_LEN = NBYTES;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BC_W  = $clog2(FRAME_LEN);

    logic [ACC_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic                 overrun_q, overrun_d;

    logic                 non_empty;
    logic                 full;
    logic                 xfer;
    logic                 last_byte;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [ACC_WIDTH-1:0] head_word;
    logic [7:0]           data_bytes [NBYTES];
    logic [7:0]           cur_byte;
`ifdef MAC_SER_CHECKSUM_EN
    logic [7:0]           checksum;
`endif

    assign non_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign xfer      = non_empty & byte_ready_i & ena;
    assign last_byte = (byte_cnt_q == BC_W'(FRAME_LEN - 1));
    assign pop       = xfer & last_byte;
    // A full FIFO still accepts a result when the head frame leaves on the same edge.
    assign push_ok   = ena & result_valid_i & (~full | pop);
    assign drop      = ena & result_valid_i & full & ~pop;
    assign head_word = mem_q[head_q];

    always_comb begin
        for (int k = 0; k < NBYTES; k++) begin
            if (MSB_FIRST != 0) begin
                data_bytes[k] = head_word[ACC_WIDTH-1-8*k -: 8];
            end else begin
                data_bytes[k] = head_word[8*k +: 8];
            end
        end
    end

`ifdef MAC_SER_CHECKSUM_EN
    always_comb begin
        checksum = '0;
        for (int k = 0; k < NBYTES; k++) begin
            checksum = checksum ^ data_bytes[k];
        end
    end
`endif

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (byte_cnt_q == BC_W'(k)) begin
                cur_byte = data_bytes[k];
            end
        end
`ifdef MAC_SER_CHECKSUM_EN
        if (byte_cnt_q == BC_W'(NBYTES)) begin
            cur_byte = checksum;
        end
`endif
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        byte_cnt_d = byte_cnt_q;
        if (xfer) begin
            byte_cnt_d = last_byte ? '0 : byte_cnt_q + BC_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_ok) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        // Set wins over a simultaneous clear.
        overrun_d = drop | (overrun_q & ~(ena & clear_i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[tail_q] <= result_i;
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign byte_valid_o = non_empty;
    assign busy_o       = non_empty;
    assign byte_o       = non_empty ? cur_byte : 8'h00;
    assign last_o       = non_empty & last_byte;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_mac_result_serializer.sv
// Bench for mac_result_serializer: queue-level reference model compared every cycle, plus literal byte-stream checks.
module tb_mac_result_serializer;

    localparam int NB    = 4;
    localparam int DEPTH = 2;
`ifdef MAC_SER_CHECKSUM_EN
    localparam int FLEN = NB + 1;
`else
    localparam int FLEN = NB;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [31:0] result_i = '0;
    logic        result_valid_i = 1'b0;
    logic        byte_ready_i = 1'b0;
    logic        clear_i = 1'b0;

    logic [7:0]  byte_o, byte_o_l;
    logic        byte_valid_o, byte_valid_o_l;
    logic        last_o, last_o_l;
    logic        busy_o, busy_o_l;
    logic        overrun_o, overrun_o_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_result_serializer #(.ACC_WIDTH(32), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .result_i(result_i), .result_valid_i(result_valid_i),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i), .last_o(last_o),
        .busy_o(busy_o), .overrun_o(overrun_o), .clear_i(clear_i)
    );

    mac_result_serializer #(.ACC_WIDTH(32), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .ena(ena), .result_i(result_i), .result_valid_i(result_valid_i),
        .byte_o(byte_o_l), .byte_valid_o(byte_valid_o_l), .byte_ready_i(byte_ready_i), .last_o(last_o_l),
        .busy_o(busy_o_l), .overrun_o(overrun_o_l), .clear_i(clear_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole results plus the index of the next byte to send.
    logic [31:0] mq[$];
    int          midx = 0;
    logic        movr = 1'b0;

    function automatic logic [7:0] model_byte(input logic [31:0] r, input int k, input bit msb);
        logic [7:0] x;
        if (k >= NB) begin
            x = r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0];
        end else if (msb) begin
            x = 8'((r >> (8 * (NB - 1 - k))) & 32'hFF);
        end else begin
            x = 8'((r >> (8 * k)) & 32'hFF);
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit pop;
        if (!rst_n) begin
            mq.delete();
            midx = 0;
            movr = 1'b0;
        end else if (ena) begin
            pop = 1'b0;
            if (mq.size() != 0 && byte_ready_i) begin
                if (midx == FLEN - 1) begin
                    pop  = 1'b1;
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (clear_i) movr = 1'b0;
            if (result_valid_i) begin
                if (mq.size() < DEPTH || pop) mq.push_back(result_i);
                else movr = 1'b1;
            end
            if (pop) void'(mq.pop_front());
        end
    end

    logic [8:0] got[$];
    logic [8:0] got_l[$];

    always @(negedge clk) begin
        logic       ev;
        logic       el;
        logic [7:0] eb, ebl;
        ev  = (mq.size() != 0);
        el  = ev && (midx == FLEN - 1);
        eb  = ev ? model_byte(mq[0], midx, 1'b1) : 8'h00;
        ebl = ev ? model_byte(mq[0], midx, 1'b0) : 8'h00;
        chk("valid",     32'(byte_valid_o),   32'(ev));
        chk("busy",      32'(busy_o),         32'(ev));
        chk("last",      32'(last_o),         32'(el));
        chk("byte",      32'(byte_o),         32'(eb));
        chk("overrun",   32'(overrun_o),      32'(movr));
        chk("lsb_valid", 32'(byte_valid_o_l), 32'(ev));
        chk("lsb_last",  32'(last_o_l),       32'(el));
        chk("lsb_byte",  32'(byte_o_l),       32'(ebl));
        if (rst_n && ena && byte_ready_i && byte_valid_o) got.push_back({last_o, byte_o});
        if (rst_n && ena && byte_ready_i && byte_valid_o_l) got_l.push_back({last_o_l, byte_o_l});
    end

    logic [8:0] exp_q[$];
    logic [8:0] exp_l[$];

    task automatic add_frame(input bit lsb, input logic [7:0] b0, b1, b2, b3, input logic [7:0] cs);
        logic [8:0] f[$];
        f.push_back({1'b0, b0});
        f.push_back({1'b0, b1});
        f.push_back({1'b0, b2});
`ifdef MAC_SER_CHECKSUM_EN
        f.push_back({1'b0, b3});
        f.push_back({1'b1, cs});
`else
        f.push_back({1'b1, b3});
        if (cs == 8'hFF) f.push_back(9'h0FF);
`endif
        if (lsb) exp_l = {exp_l, f};
        else exp_q = {exp_q, f};
    endtask

    task automatic chk_stream(input string nm, input logic [8:0] g[$], input logic [8:0] e[$]);
        chk({nm, "_len"}, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < g.size()) chk(nm, 32'(g[i]), 32'(e[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] v);
        result_i = v;
        result_valid_i = 1'b1;
        step();
        result_valid_i = 1'b0;
    endtask

    task automatic restart_streams();
        got.delete();
        got_l.delete();
        exp_q.delete();
        exp_l.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid",   32'(byte_valid_o), 32'd0);
        chk("rst_byte",    32'(byte_o),       32'd0);
        chk("rst_overrun", 32'(overrun_o),    32'd0);
        rst_n = 1'b1;
        step();

        // MSB- and LSB-first frames, continuous ready, first byte one cycle after the push
        restart_streams();
        byte_ready_i = 1'b1;
        push(32'h12345678);
        chk("lat_valid", 32'(byte_valid_o), 32'd1);
        chk("lat_byte",  32'(byte_o),       32'h12);
        repeat (FLEN + 1) step();
        chk("t1_idle", 32'(busy_o), 32'd0);
        add_frame(1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
        add_frame(1'b1, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
        chk_stream("t1_msb", got, exp_q);
        chk_stream("t1_lsb", got_l, exp_l);

        // Intermittent ready
        restart_streams();
        byte_ready_i = 1'b0;
        push(32'hCAFEF00D);
        for (int i = 0; i < 18; i++) begin
            byte_ready_i = (i % 3 == 0);
            step();
        end
        byte_ready_i = 1'b0;
        add_frame(1'b0, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC9);
        chk_stream("t2_stall", got, exp_q);

        // Enable low freezes everything
        ena = 1'b0;
        result_i = 32'hDEADBEEF;
        result_valid_i = 1'b1;
        byte_ready_i = 1'b1;
        clear_i = 1'b1;
        repeat (2) step();
        ena = 1'b1;
        result_valid_i = 1'b0;
        byte_ready_i = 1'b0;
        clear_i = 1'b0;
        chk("ena_idle", 32'(busy_o), 32'd0);

        // Overrun on the third result while stalled, then clear
        restart_streams();
        push(32'h11111111);
        push(32'h22222222);
        push(32'h33333333);
        chk("t3_overrun", 32'(overrun_o), 32'd1);
        byte_ready_i = 1'b1;
        repeat (2 * FLEN + 2) step();
        byte_ready_i = 1'b0;
        add_frame(1'b0, 8'h11, 8'h11, 8'h11, 8'h11, 8'h00);
        add_frame(1'b0, 8'h22, 8'h22, 8'h22, 8'h22, 8'h00);
        chk_stream("t3_drop", got, exp_q);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t3_clear", 32'(overrun_o), 32'd0);

        // Push into a full FIFO on the edge that pops the head frame
        restart_streams();
        push(32'h10203040);
        push(32'h50607080);
        byte_ready_i = 1'b1;
        repeat (FLEN - 1) step();
        push(32'h0F0F0F0F);
        chk("t4_no_overrun", 32'(overrun_o), 32'd0);
        repeat (2 * FLEN - 1) step();
        chk("t4_still_busy", 32'(busy_o), 32'd1);
        step();
        chk("t4_done", 32'(busy_o), 32'd0);
        add_frame(1'b0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40);
        add_frame(1'b0, 8'h50, 8'h60, 8'h70, 8'h80, 8'hC0);
        add_frame(1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00);
        chk_stream("t4_full_pop", got, exp_q);

        // Asynchronous reset mid-frame, then a clean frame
        push(32'hA1B2C3D4);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",   32'(byte_valid_o), 32'd0);
        chk("t5_rst_byte",    32'(byte_o),       32'd0);
        chk("t5_rst_last",    32'(last_o),       32'd0);
        chk("t5_rst_busy",    32'(busy_o),       32'd0);
        step();
        rst_n = 1'b1;
        step();
        restart_streams();
        push(32'h01020304);
        begin
            int n = 0;
            while (busy_o && n < 40) begin
                step();
                n++;
            end
            chk("t5_drain_timeout", 32'(busy_o), 32'd0);
        end
        byte_ready_i = 1'b0;
        add_frame(1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        chk_stream("t5_after_rst", got, exp_q);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
